// File: rtl/acc_seq_pkg.sv
// Shared types and defaults for the per-lane weight accumulator sequencer.
//
// Lane geometry normally comes from the project-wide DEF.sv macros. When this
// slice is built on its own those macros are absent, so fallbacks are defined
// here to let the block elaborate stand-alone.
`ifndef DIM_C
`define DIM_C 4
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif

package acc_seq_pkg;

  localparam int P_DIM_C        = `DIM_C;
  localparam int P_WEIGHT_WIDTH = `WEIGHT_WIDTH;
  localparam int P_ACC_WIDTH    = `ACC_WIDTH;
  localparam int P_LEN_W        = 8;

  // Sequencer states; 3 bits so the debug port width is fixed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    SETTLE = 3'd3,
    OUT    = 3'd4
  } acc_seq_state_e;

  typedef logic [P_LEN_W-1:0]                    len_t;
  typedef logic [P_DIM_C*P_WEIGHT_WIDTH-1:0]     wvec_t;
  typedef logic [P_DIM_C*P_ACC_WIDTH-1:0]        svec_t;

endpackage

// File: rtl/acc_weight_seq_if.sv
// Bundle of every non-clock signal of acc_weight_seq.
//
// Handshake rule for all three streams (cfg, in, out): a transfer happens on
// the rising clk edge where valid && ready are both high. The source holds
// valid and its payload stable until that edge; ready may be high without
// valid and carries no obligation.
//
//   cfg_valid/cfg_ready/cfg_len : job request, cfg_len = number of beats
//   in_valid/in_ready/in_val    : weight vector stream
//   acc_en/acc_clear/acc_val    : command side of the external accumulator
//   acc_sum                     : accumulator registered sum
//   out_valid/out_ready/out_sum : captured job result
//   busy                        : sequencer not idle
//   dbg_state/dbg_count         : FSM state and beat counter for observation
//
// slave  = the sequencer side, master = the environment side.
interface acc_weight_seq_if
  import acc_seq_pkg::*;
#(
  parameter int DIM_C        = P_DIM_C,
  parameter int WEIGHT_WIDTH = P_WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = P_ACC_WIDTH,
  parameter int LEN_W        = P_LEN_W
);

  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [LEN_W-1:0]              cfg_len;
  logic                          in_valid;
  logic                          in_ready;
  logic [DIM_C*WEIGHT_WIDTH-1:0] in_val;
  logic                          acc_en;
  logic                          acc_clear;
  logic [DIM_C*WEIGHT_WIDTH-1:0] acc_val;
  logic [DIM_C*ACC_WIDTH-1:0]    acc_sum;
  logic                          out_valid;
  logic                          out_ready;
  logic [DIM_C*ACC_WIDTH-1:0]    out_sum;
  logic                          busy;
  acc_seq_state_e                dbg_state;
  logic [LEN_W-1:0]              dbg_count;

  modport slave (
    input  cfg_valid, cfg_len, in_valid, in_val, acc_sum, out_ready,
    output cfg_ready, in_ready, acc_en, acc_clear, acc_val,
           out_valid, out_sum, busy, dbg_state, dbg_count
  );

  modport master (
    output cfg_valid, cfg_len, in_valid, in_val, acc_sum, out_ready,
    input  cfg_ready, in_ready, acc_en, acc_clear, acc_val,
           out_valid, out_sum, busy, dbg_state, dbg_count
  );

endinterface

// File: rtl/acc_beat_counter.sv
// Beat counter for one accumulation job.
//
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : start of job, latch len_i and zero the count
//   inc_i     : one beat accepted
//   len_i     : job length in beats
//   last_o    : the current count is the final beat index (len-1)
//   zero_o    : the latched job length is zero
//   count_o   : beats accepted so far
module acc_beat_counter
  import acc_seq_pkg::*;
#(
  parameter int LEN_W = P_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             last_o,
  output logic             zero_o,
  output logic [LEN_W-1:0] count_o
);

  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      len_q   <= '0;
    end else if (load_i) begin
      count_q <= '0;
      len_q   <= len_i;
    end else if (inc_i) begin
      count_q <= count_q + LEN_W'(1);
    end
  end

  // For len_q == 0 the compare target wraps to all ones; harmless because the
  // sequencer never enters the beat phase for an empty job, and the count never
  // passes len_q-1, so it cannot wrap either.
  assign last_o  = (count_q == (len_q - LEN_W'(1)));
  assign zero_o  = (len_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/acc_weight_seq.sv
// Sequencer for the per-lane weight accumulator.
//
// A job of N beats first clears the accumulator for one cycle, then steers
// exactly N weight vectors into it, waits one cycle for the accumulator's
// registered sum to include the last beat, captures that sum and offers it on
// the result port until it is taken.
//
//   clk  : clock
//   rst  : synchronous active-high reset; aborts any job in flight
//   bus  : acc_weight_seq_if.slave -- cfg, in, accumulator, out streams,
//          busy and debug state/count
module acc_weight_seq
  import acc_seq_pkg::*;
#(
  parameter int DIM_C        = P_DIM_C,
  parameter int WEIGHT_WIDTH = P_WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = P_ACC_WIDTH,
  parameter int LEN_W        = P_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  acc_weight_seq_if.slave    bus
);

  acc_seq_state_e                state_q, state_d;
  logic [DIM_C*ACC_WIDTH-1:0]    out_sum_q;
  logic [DIM_C*WEIGHT_WIDTH-1:0] acc_val_w;
  logic [LEN_W-1:0]              count_w;

  logic cfg_ready_c, in_ready_c, acc_en_c, clear_c, out_valid_c;
  logic load_c, inc_c, capture_c, last_c, zero_c;

  acc_beat_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_c),
    .inc_i   (inc_c),
    .len_i   (bus.cfg_len),
    .last_o  (last_c),
    .zero_o  (zero_c),
    .count_o (count_w)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // SETTLE is the first cycle in which the accumulator's registered sum
  // includes the final beat, so the capture happens on that edge.
  always_ff @(posedge clk) begin
    if (rst)            out_sum_q <= '0;
    else if (capture_c) out_sum_q <= bus.acc_sum;
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_c = 1'b0;
    in_ready_c  = 1'b0;
    acc_en_c    = 1'b0;
    clear_c     = 1'b0;
    out_valid_c = 1'b0;
    load_c      = 1'b0;
    inc_c       = 1'b0;
    capture_c   = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready_c = 1'b1;
        if (bus.cfg_valid) begin
          load_c  = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clear_c = 1'b1;
        state_d = zero_c ? SETTLE : ACCUM;
      end
      ACCUM: begin
        in_ready_c = 1'b1;
        // Gated by rst so enable never overlaps the reset-time clear.
        if (bus.in_valid && !rst) begin
          acc_en_c = 1'b1;
          inc_c    = 1'b1;
          if (last_c) state_d = SETTLE;
        end
      end
      SETTLE: begin
        capture_c = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The weight vector is passed straight through; acc_en alone decides whether
  // the accumulator consumes it.
  assign acc_val_w     = bus.in_val;

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.acc_en    = acc_en_c;
  assign bus.acc_clear = clear_c | rst;
  assign bus.acc_val   = acc_val_w;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sum   = out_sum_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;
  assign bus.dbg_count = count_w;

endmodule

// File: tb/tb_acc_weight_seq.sv
// Directed bench for acc_weight_seq with a stand-in accumulator, a result
// scoreboard and a per-cycle rule checker.
module tb_acc_weight_seq;
  import acc_seq_pkg::*;

  localparam int DC = P_DIM_C;
  localparam int WW = P_WEIGHT_WIDTH;
  localparam int AW = P_ACC_WIDTH;
  localparam int LW = P_LEN_W;
  localparam int VW = DC*WW;
  localparam int SW = DC*AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  acc_weight_seq_if #(.DIM_C(DC), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .LEN_W(LW)) bus ();

  acc_weight_seq #(.DIM_C(DC), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .LEN_W(LW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in accumulator: registered per-lane sum, clear has priority.
  logic [AW-1:0] lane_q [DC];
  always @(posedge clk) begin
    for (int l = 0; l < DC; l++) begin
      if (bus.acc_clear)   lane_q[l] <= '0;
      else if (bus.acc_en) lane_q[l] <= lane_q[l] + AW'(bus.acc_val[l*WW +: WW]);
    end
  end
  for (genvar g = 0; g < DC; g++) begin : g_sum
    assign bus.acc_sum[g*AW +: AW] = lane_q[g];
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int hs_cyc, last_hs, en_cnt, clr_cnt;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  // Lane l carries v+l so lane mix-ups show up in the sums.
  function automatic logic [VW-1:0] wrep(input int v);
    logic [VW-1:0] r;
    for (int l = 0; l < DC; l++) r[l*WW +: WW] = WW'(v + l);
    return r;
  endfunction

  // Model: each lane's result is the plain sum of what was sent to that lane.
  function automatic logic [SW-1:0] model_sum(input int vals[$]);
    logic [SW-1:0] r;
    for (int l = 0; l < DC; l++) begin
      int s = 0;
      foreach (vals[i]) s += vals[i] + l;
      r[l*AW +: AW] = AW'(s);
    end
    return r;
  endfunction

  // ---------------- per-cycle compare process ----------------
  logic          prev_hold = 1'b0;
  logic [SW-1:0] prev_sum  = '0;
  always @(negedge clk) begin
    if (!rst) begin
      check("clear_en_excl", bus.acc_en & bus.acc_clear, 0);
      check("acc_en_rule", bus.acc_en, bus.in_valid & bus.in_ready);
      if (bus.in_ready) check("acc_val_pass", bus.acc_val, bus.in_val);
      check("busy_vs_cfg_ready", bus.busy, !bus.cfg_ready);
      if (bus.acc_en)    en_cnt++;
      if (bus.acc_clear) clr_cnt++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) fail_now("out_unexpected");
        else check("out_sum", bus.out_sum, exp_q[0]);
        if (prev_hold) check("out_stable", bus.out_sum, prev_sum);
        if (bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      prev_hold = bus.out_valid & !bus.out_ready;
      prev_sum  = bus.out_sum;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the cfg handshake edge.
  task automatic start_cfg(input int len);
    int n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_len   = LW'(len);
    @(negedge clk);
    while (!bus.cfg_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.cfg_ready) fail_now("cfg_timeout");
    hs_cyc  = cyc;
    en_cnt  = 0;
    clr_cnt = 0;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
  endtask

  // Sends vals as beats; bubble inserts one idle cycle between beats.
  // Returns at the negedge one cycle after the last handshake.
  task automatic feed(input int vals[$], input bit bubble);
    foreach (vals[i]) begin
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_val   = wrep(vals[i]);
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
      if (!bus.in_ready) begin
        fail_now("in_ready_timeout");
        bus.in_valid = 1'b0;
        return;
      end
      if (i == 0) check("cfg_to_in_ready", cyc - hs_cyc, 2);
      last_hs = cyc;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_val   = wrep(8'h5a);
      if (bubble && i < vals.size() - 1) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    check("in_ready_after_last", bus.in_ready, 0);
  endtask

  task automatic wait_valid(input int from, input int lat, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 20);
    if (!bus.out_valid) fail_now(name);
    else check(name, cyc - from, lat);
  endtask

  task automatic take_out();
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_out", {bus.out_valid, bus.busy, bus.cfg_ready}, 3'b001);
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int vals[$], input bit bubble, input int lit0);
    exp_q.push_back(model_sum(vals));
    start_cfg(vals.size());
    if (vals.size() > 0) begin
      feed(vals, bubble);
      wait_valid(last_hs, 2, "last_beat_to_out");
    end else begin
      wait_valid(hs_cyc, 3, "len0_cfg_to_out");
    end
    check("lane0_literal", bus.out_sum[AW-1:0], lit0);
    check("acc_en_pulses", en_cnt, vals.size());
    check("clear_pulses", clr_cnt, 1);
    take_out();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int q[$];
    bus.cfg_valid = 1'b0;
    bus.cfg_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_val    = '0;
    bus.out_ready = 1'b0;

    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_values",
          {bus.cfg_ready, bus.in_ready, bus.acc_en, bus.acc_clear, bus.out_valid, bus.busy},
          6'b100100);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_state", bus.dbg_state, IDLE);
    check("rst_count", bus.dbg_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // len=3, continuous valid: lane0 = 5+7+9.
    q = '{5, 7, 9};
    run_job(q, 1'b0, 21);

    // len=4 with bubbles between beats: lane0 = 4.
    q = '{1, 1, 1, 1};
    run_job(q, 1'b1, 4);

    // Empty job.
    q.delete();
    run_job(q, 1'b0, 0);

    // Result held for 10 cycles with a pending cfg that must wait.
    q = '{5, 7, 9};
    exp_q.push_back(model_sum(q));
    start_cfg(3);
    feed(q, 1'b0);
    wait_valid(last_hs, 2, "hold_out_latency");
    q.delete();
    exp_q.push_back(model_sum(q));
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1;
    bus.cfg_len   = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_cfg_blocked", bus.cfg_ready, 0);
      check("hold_sum_lane0", bus.out_sum[AW-1:0], 21);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_hold", {bus.cfg_ready, bus.busy}, 2'b10);
    hs_cyc  = cyc;
    en_cnt  = 0;
    clr_cnt = 0;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    check("held_cfg_accepted", {bus.busy, bus.acc_clear}, 2'b11);
    wait_valid(hs_cyc, 3, "held_len0_to_out");
    check("held_len0_sum", bus.out_sum, 0);
    check("held_len0_en", en_cnt, 0);
    check("held_len0_clr", clr_cnt, 1);
    take_out();

    // Reset in the middle of a 4-beat job, after 2 beats.
    start_cfg(4);
    bus.in_valid = 1'b1;
    bus.in_val   = wrep(1);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
      if (!bus.in_ready) fail_now("abort_in_ready");
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_two_beats", bus.dbg_count, 2);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_clear", {bus.acc_clear, bus.acc_en}, 2'b10);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("abort_after_rst",
          {bus.busy, bus.cfg_ready, bus.out_valid, bus.acc_clear, bus.in_ready},
          5'b01010);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back jobs; the second must not see the first's sum.
    q = '{3, 3};
    run_job(q, 1'b0, 6);
    q = '{10};
    run_job(q, 1'b0, 10);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
